// File: rtl/rv_mem_pkg.sv
// Shared sizing helpers for SRAM-backed streaming blocks.
package rv_mem_pkg;

    localparam int unsigned OBUF_DEPTH = 2;
    localparam int unsigned OBUF_CW    = 2;

    function automatic int unsigned depth_f(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

    // Level counts SRAM words plus one in-flight read plus the output buffer.
    function automatic int unsigned level_w_f(input int unsigned aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/rv_sram_fifo_obuf.sv
// Two-entry output buffer absorbing the SRAM read latency; capture and pop may
// coincide.
module rv_sram_fifo_obuf
    import rv_mem_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                 sclk,
    input  logic                 rstn,
    input  logic                 i_wr_en,
    input  logic [DW-1:0]        i_wr_data,
    input  logic                 i_pop,
    output logic                 o_valid,
    output logic [DW-1:0]        o_data,
    output logic [OBUF_CW-1:0]   o_count
);

    logic [DW-1:0]      r_ent [OBUF_DEPTH];
    logic               r_head;
    logic [OBUF_CW-1:0] r_cnt;
    logic               w_pop;
    logic               w_wr_slot;

    assign w_pop     = i_pop & (r_cnt != '0);
    // Tail slot; with two entries held and a pop, this is the slot being vacated.
    assign w_wr_slot = r_head ^ r_cnt[0];

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_ent[0] <= '0;
            r_ent[1] <= '0;
            r_head   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_wr_en) begin
                r_ent[w_wr_slot] <= i_wr_data;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (i_wr_en && !w_pop) begin
                r_cnt <= r_cnt + OBUF_CW'(1);
            end else if (!i_wr_en && w_pop) begin
                r_cnt <= r_cnt - OBUF_CW'(1);
            end
        end
    end

    assign o_valid = (r_cnt != '0);
    assign o_data  = r_ent[r_head];
    assign o_count = r_cnt;

endmodule

// File: rtl/rv_sram_fifo_ctrl.sv
// Valid/ready FIFO controller over an external 1W/1R SRAM with 1-cycle read latency.
// Define RV_SRAM_FIFO_LEVEL_EN to add the level/afull outputs.
module rv_sram_fifo_ctrl
    import rv_mem_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 6,
    parameter int unsigned AFULL_TH = 56
) (
    input  logic          sclk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          sram_wr_en,
    output logic [AW-1:0] sram_wr_addr,
    output logic [DW-1:0] sram_wr_data,
    output logic          sram_rd_en,
    output logic [AW-1:0] sram_rd_addr,
    input  logic [DW-1:0] sram_rd_data
`ifdef RV_SRAM_FIFO_LEVEL_EN
    ,
    output logic [AW+1:0] level,
    output logic          afull
`endif
);

    localparam int unsigned DEPTH = depth_f(AW);
    localparam int unsigned LW    = level_w_f(AW);

    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [AW:0]        r_mem_cnt;
    logic               r_rd_pend;
    logic               r_act;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_issue;
    logic [OBUF_CW-1:0] w_ob_cnt;

    // r_act keeps in_ready low until the first edge after reset release.
    assign in_ready = r_act & (r_mem_cnt != (AW+1)'(DEPTH));
    assign w_push   = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;
    assign w_rd_issue = (r_mem_cnt != '0) &
                        ((3'(w_ob_cnt) + 3'(r_rd_pend)) < (3'd2 + 3'(w_pop)));

    assign sram_wr_en   = w_push;
    assign sram_wr_addr = r_wptr;
    assign sram_wr_data = in_data;
    assign sram_rd_en   = w_rd_issue;
    assign sram_rd_addr = r_rptr;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_act     <= 1'b0;
        end else begin
            r_act     <= 1'b1;
            r_rd_pend <= w_rd_issue;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_issue) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_rd_issue) begin
                r_mem_cnt <= r_mem_cnt + (AW+1)'(1);
            end else if (!w_push && w_rd_issue) begin
                r_mem_cnt <= r_mem_cnt - (AW+1)'(1);
            end
        end
    end

    rv_sram_fifo_obuf #(
        .DW (DW)
    ) u_obuf (
        .sclk      (sclk),
        .rstn      (rstn),
        .i_wr_en   (r_rd_pend),
        .i_wr_data (sram_rd_data),
        .i_pop     (w_pop),
        .o_valid   (out_valid),
        .o_data    (out_data),
        .o_count   (w_ob_cnt)
    );

`ifdef RV_SRAM_FIFO_LEVEL_EN
    assign level = LW'(r_mem_cnt) + LW'(r_rd_pend) + LW'(w_ob_cnt);
    assign afull = (level >= LW'(AFULL_TH));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(AFULL_TH), 32'(LW)};
`endif

endmodule
